// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper motion controller: drive modes,
// controller states and the eight-entry coil pattern table.
package stepper_pkg;

  typedef enum logic [1:0] {
    MODE_WAVE     = 2'd0,
    MODE_TWOPHASE = 2'd1,
    MODE_HALF     = 2'd2,
    MODE_HALF_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_e;

  // Index 0 is the rightmost entry; even indices energise one coil, odd two.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0101, 4'b0100,
    4'b0110, 4'b0010, 4'b1010, 4'b1000
  };

  localparam int unsigned MIN_DELAY = 2;

  function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
    return PHASE_TABLE[idx];
  endfunction

endpackage

// File: rtl/phase_sequencer.sv
// Phase index register with full-step parity correction and the coil table lookup.
module phase_sequencer
  import stepper_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       advance,
  input  logic       direction,
  input  mode_e      mode,
  output logic [3:0] pattern
);

  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [2:0] stride;

  // A full-step mode sitting on the wrong parity takes a single half step first.
  always_comb begin
    stride = 3'd1;
    case (mode)
      MODE_WAVE:     stride = idx_q[0] ? 3'd1 : 3'd2;
      MODE_TWOPHASE: stride = idx_q[0] ? 3'd2 : 3'd1;
      default:       stride = 3'd1;
    endcase
    idx_d = idx_q;
    if (advance) begin
      idx_d = direction ? idx_q + stride : idx_q - stride;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Pattern for the index after this cycle's advance, so the parent can register it.
  assign pattern = phase_pattern(idx_d);

endmodule

// File: rtl/stepper_motion_ctrl.sv
// Bounded-move stepper controller: trapezoidal step-interval profile, three drive
// modes, busy/done handshake; phase position persists across moves.
module stepper_motion_ctrl
  import stepper_pkg::*;
#(
  parameter int DELAY_W = 32,
  parameter int STEPS_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               direction,
  input  logic [1:0]         mode,
  input  logic [STEPS_W-1:0] step_count,
  input  logic [DELAY_W-1:0] start_delay,
  input  logic [DELAY_W-1:0] cruise_delay,
  input  logic [DELAY_W-1:0] ramp_dec,
  input  logic               hold_en,
  output logic [3:0]         phases_out,
  output logic               step_pulse,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] steps_remaining
);

  function automatic logic [DELAY_W-1:0] clamp_min(input logic [DELAY_W-1:0] d);
    return (d < DELAY_W'(MIN_DELAY)) ? DELAY_W'(MIN_DELAY) : d;
  endfunction

  // cur never drops below floor, so cur - floor cannot wrap.
  function automatic logic [DELAY_W-1:0] sat_sub(input logic [DELAY_W-1:0] cur,
                                                 input logic [DELAY_W-1:0] dec,
                                                 input logic [DELAY_W-1:0] floor);
    return (dec >= cur - floor) ? floor : cur - dec;
  endfunction

  function automatic logic [DELAY_W-1:0] sat_add(input logic [DELAY_W-1:0] cur,
                                                 input logic [DELAY_W-1:0] inc,
                                                 input logic [DELAY_W-1:0] ceil);
    logic [DELAY_W:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum > {1'b0, ceil}) ? ceil : sum[DELAY_W-1:0];
  endfunction

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DELAY_W-1:0] cur_q, cur_d;
  logic [STEPS_W-1:0] ramp_q, ramp_d, ramp_next;
  logic [STEPS_W-1:0] rem_d;
  logic [DELAY_W-1:0] sd_q, cd_q, rd_q;
  logic               dir_q;
  mode_e              mode_q;
  logic               done_d, fire, load, step_evt, energise;
  logic [DELAY_W-1:0] cd_clamped, sd_floor, sd_clamped;
  logic [3:0]         seq_pattern;

  assign cd_clamped = clamp_min(cruise_delay);
  assign sd_floor   = clamp_min(start_delay);
  assign sd_clamped = (sd_floor < cd_clamped) ? cd_clamped : sd_floor;
  assign step_evt   = (state_q != ST_IDLE) && (cnt_q == cur_q - DELAY_W'(1));
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    ramp_d    = ramp_q;
    rem_d     = steps_remaining;
    done_d    = 1'b0;
    fire      = 1'b0;
    load      = 1'b0;
    ramp_next = (state_q == ST_ACCEL) ? ramp_q + STEPS_W'(1) : ramp_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          load   = 1'b1;
          cnt_d  = '0;
          ramp_d = '0;
          rem_d  = step_count;
          cur_d  = sd_clamped;
          if (step_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ACCEL;
          end
        end
      end
      default: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (step_evt) begin
          fire   = 1'b1;
          cnt_d  = '0;
          rem_d  = steps_remaining - STEPS_W'(1);
          ramp_d = ramp_next;
          if (rem_d == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if ((state_q != ST_DECEL) && (rem_d <= ramp_next)) begin
            // Mirror the ramp: start slowing from the interval just used.
            state_d = ST_DECEL;
            cur_d   = sat_add(cur_q, rd_q, sd_q);
          end else if (state_q == ST_ACCEL) begin
            cur_d = sat_sub(cur_q, rd_q, cd_q);
            if (cur_d == cd_q) begin
              state_d = ST_CRUISE;
            end
          end else if (state_q == ST_DECEL) begin
            cur_d = sat_add(cur_q, rd_q, sd_q);
          end
        end else begin
          cnt_d = cnt_q + DELAY_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Coils stay driven on the final step's pulse cycle even though busy has dropped.
  assign energise = (state_d != ST_IDLE) || hold_en || fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q           <= '0;
      ramp_q          <= '0;
      steps_remaining <= '0;
      step_pulse      <= 1'b0;
      done            <= 1'b0;
      phases_out      <= 4'b0000;
    end else begin
      cnt_q           <= cnt_d;
      ramp_q          <= ramp_d;
      steps_remaining <= rem_d;
      step_pulse      <= fire;
      done            <= done_d;
      phases_out      <= energise ? seq_pattern : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sd_q   <= sd_clamped;
      cd_q   <= cd_clamped;
      rd_q   <= ramp_dec;
      dir_q  <= direction;
      mode_q <= mode_e'(mode);
    end
    cur_q <= cur_d;
  end

  phase_sequencer u_phase_sequencer (
    .clk       (clk),
    .reset_n   (reset_n),
    .advance   (fire),
    .direction (dir_q),
    .mode      (mode_q),
    .pattern   (seq_pattern)
  );

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// Directed bench for stepper_motion_ctrl: cycle-level behavioural model plus
// hand-computed gap and pattern expectations for each move.
module tb_stepper_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        direction = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] step_count = '0;
  logic [31:0] start_delay = '0;
  logic [31:0] cruise_delay = '0;
  logic [31:0] ramp_dec = '0;
  logic        hold_en = 1'b0;
  logic [3:0]  phases_out;
  logic        step_pulse;
  logic        busy;
  logic        done;
  logic [15:0] steps_remaining;

  stepper_motion_ctrl #(.DELAY_W(32), .STEPS_W(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .direction       (direction),
    .mode            (mode),
    .step_count      (step_count),
    .start_delay     (start_delay),
    .cruise_delay    (cruise_delay),
    .ramp_dec        (ramp_dec),
    .hold_en         (hold_en),
    .phases_out      (phases_out),
    .step_pulse      (step_pulse),
    .busy            (busy),
    .done            (done),
    .steps_remaining (steps_remaining)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_val(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] tbl [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                          4'b0100, 4'b0101, 4'b0001, 4'b1001};
  bit         m_busy = 0, m_pulse = 0, m_done = 0, m_dir = 0;
  int         m_mode = 0, m_idx = 0, m_rem = 0;
  longint     m_wait = 0;
  logic [3:0] m_phase = 4'b0000;
  longint     m_gaps[$];

  function automatic void build_gaps(input longint sd, input longint cd,
                                     input longint rd, input int n);
    longint d;
    int     up;
    bit     rising, falling;
    d = sd; up = 0; rising = 1; falling = 0;
    m_gaps.delete();
    for (int k = 0; k < n; k++) begin
      int left;
      left = n - 1 - k;
      m_gaps.push_back(d);
      if (rising) up++;
      if (!falling && left > 0 && left <= up) begin
        falling = 1; rising = 0;
        d = (d + rd > sd) ? sd : d + rd;
      end else if (falling) begin
        d = (d + rd > sd) ? sd : d + rd;
      end else if (rising) begin
        d = (d - rd < cd) ? cd : d - rd;
        if (d == cd) rising = 0;
      end
    end
  endfunction

  function automatic int next_idx(input int idx, input bit fwd, input int md);
    int stride;
    stride = 1;
    if (md == 0 && idx % 2 == 0) stride = 2;
    if (md == 1 && idx % 2 == 1) stride = 2;
    return fwd ? (idx + stride) % 8 : (idx + 8 - stride) % 8;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_pulse = 0; m_done = 0; m_rem = 0; m_idx = 0; m_wait = 0;
      m_phase = 4'b0000;
      m_gaps.delete();
    end else begin
      m_pulse = 0;
      m_done  = 0;
      if (!m_busy) begin
        if (start && !abort) begin
          longint sd, cd;
          m_dir  = direction;
          m_mode = int'(mode);
          m_rem  = int'(step_count);
          sd = (start_delay < 2) ? 2 : longint'(start_delay);
          cd = (cruise_delay < 2) ? 2 : longint'(cruise_delay);
          if (sd < cd) sd = cd;
          if (m_rem == 0) m_done = 1;
          else begin
            build_gaps(sd, cd, longint'(ramp_dec), m_rem);
            m_wait = m_gaps.pop_front();
            m_busy = 1;
          end
        end
      end else if (abort) begin
        m_busy = 0;
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          m_pulse = 1;
          m_rem--;
          m_idx = next_idx(m_idx, m_dir, m_mode);
          if (m_rem == 0) begin
            m_busy = 0;
            m_done = 1;
          end else m_wait = m_gaps.pop_front();
        end
      end
      m_phase = (m_busy || hold_en || m_pulse) ? tbl[m_idx] : 4'b0000;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check_val("step_pulse", step_pulse, m_pulse);
      check_val("busy", busy, m_busy);
      check_val("done", done, m_done);
      check_val("steps_remaining", steps_remaining, m_rem);
      check_val("phases_out", phases_out, m_phase);
    end
  end

  // ---------------- observation of gaps / patterns ----------------
  int         cyc = 0;
  int         rise_cyc = 0;
  int         done_cyc = -1;
  bit         prev_busy = 0;
  int         pulse_cyc[$];
  logic [3:0] pat_q[$];
  int         exp_q[$];
  logic [3:0] exp_pat[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (step_pulse) begin
      pulse_cyc.push_back(cyc);
      pat_q.push_back(phases_out);
    end
    if (busy && !prev_busy) rise_cyc = cyc;
    prev_busy = busy;
    if (done) done_cyc = cyc;
  end

  task automatic check_gaps(input string name);
    check_val({name, "_count"}, pulse_cyc.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pulse_cyc.size(); i++)
      check_val(name, (i == 0) ? pulse_cyc[0] - rise_cyc : pulse_cyc[i] - pulse_cyc[i-1],
                exp_q[i]);
  endtask

  task automatic check_pats(input string name);
    check_val({name, "_count"}, pat_q.size(), exp_pat.size());
    for (int i = 0; i < exp_pat.size() && i < pat_q.size(); i++)
      check_val(name, pat_q[i], exp_pat[i]);
  endtask

  task automatic run_move(input bit dir, input int md, input int cnt,
                          input int sd, input int cd, input int rd);
    @(posedge clk); #1;
    pulse_cyc.delete();
    pat_q.delete();
    done_cyc     = -1;
    direction    = dir;
    mode         = md[1:0];
    step_count   = cnt[15:0];
    start_delay  = sd;
    cruise_delay = cd;
    ramp_dec     = rd;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val({name, "_done_seen"}, done, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_pulses(input string name, input int n, input int budget);
    int seen, k;
    seen = 0; k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      if (step_pulse) seen++;
      k++;
    end
    if (seen < n) check_val({name, "_pulse_timeout"}, seen, n);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_phases", phases_out, 0);
    check_val("rst_pulse", step_pulse, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_rem", steps_remaining, 0);
    reset_n = 1'b1;
    chk_en  = 1;

    // Full trapezoid, half-step forward from index 0
    run_move(1, 2, 6, 10, 4, 3);
    check_val("t1_busy_rise", busy, 1);
    check_val("t1_rem_load", steps_remaining, 6);
    wait_done("t1", 200);
    exp_q = '{10, 7, 4, 4, 7, 10};
    check_gaps("t1_gap");
    exp_pat = '{4'b1010, 4'b0010, 4'b0110, 4'b0100, 4'b0101, 4'b0001};
    check_pats("t1_pat");
    check_val("t1_done_on_last", done_cyc, (pulse_cyc.size() == 6) ? pulse_cyc[5] : -2);

    // Too short to reach cruise
    run_move(1, 2, 3, 10, 4, 3);
    wait_done("t2", 200);
    exp_q = '{10, 7, 10};
    check_gaps("t2_gap");

    // Ramp that overshoots cruise and start delay saturates both ways
    run_move(1, 2, 6, 10, 5, 3);
    wait_done("t3", 200);
    exp_q = '{10, 7, 5, 5, 8, 10};
    check_gaps("t3_gap");

    // Delays below the minimum, and start slower than cruise
    run_move(1, 2, 3, 0, 1, 0);
    wait_done("t4a", 100);
    exp_q = '{2, 2, 2};
    check_gaps("t4a_gap");
    run_move(1, 2, 3, 3, 6, 1);
    wait_done("t4b", 100);
    exp_q = '{6, 6, 6};
    check_gaps("t4b_gap");

    // Index now 5; four half steps bring it to 1, then wave reverse
    run_move(1, 2, 4, 2, 2, 0);
    wait_done("t5_setup", 100);
    run_move(0, 0, 2, 4, 4, 0);
    wait_done("t5", 100);
    exp_pat = '{4'b1000, 4'b0001};
    check_pats("t5_pat");
    repeat (2) @(posedge clk);
    #1;
    check_val("t5_idle_phases", phases_out, 4'b0000);

    // Index 6 -> 1, then wave reverse with hold
    run_move(1, 2, 3, 2, 2, 0);
    wait_done("t6_setup", 100);
    hold_en = 1'b1;
    run_move(0, 0, 2, 4, 4, 0);
    wait_done("t6", 100);
    exp_pat = '{4'b1000, 4'b0001};
    check_pats("t6_pat");
    repeat (3) @(posedge clk);
    #1;
    check_val("t6_hold_phases", phases_out, 4'b0001);
    hold_en = 1'b0;

    // Two-phase from even index 6: parity fix to 7, then +2 to 1
    run_move(1, 1, 2, 3, 3, 0);
    wait_done("t7", 100);
    exp_pat = '{4'b1001, 4'b1010};
    check_pats("t7_pat");

    // Zero-step move
    run_move(1, 2, 0, 5, 5, 1);
    check_val("t8_done", done, 1);
    check_val("t8_busy", busy, 0);
    @(posedge clk); #1;
    check_val("t8_done_clear", done, 0);

    // Start while busy is ignored
    run_move(1, 2, 5, 6, 6, 1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; step_count = 16'd9; direction = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("t9_rem_unchanged", steps_remaining, 5);
    wait_done("t9", 200);
    exp_q = '{6, 6, 6, 6, 6};
    check_gaps("t9_gap");

    // Abort and start together in idle
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; step_count = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_val("t10_busy", busy, 0);
    check_val("t10_done", done, 0);
    repeat (8) @(posedge clk);

    // Abort on the third step-event cycle (third interval is 4)
    run_move(1, 2, 10, 8, 4, 2);
    wait_pulses("t11", 2, 100);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("t11_busy", busy, 0);
    check_val("t11_rem", steps_remaining, 8);
    repeat (20) @(posedge clk);
    #1;
    check_val("t11_pulses", pulse_cyc.size(), 2);
    check_val("t11_no_done", done_cyc, -1);

    // Reset in the middle of cruise
    run_move(1, 2, 20, 10, 4, 3);
    wait_pulses("t12", 4, 200);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("t12_phases", phases_out, 0);
    check_val("t12_pulse", step_pulse, 0);
    check_val("t12_busy", busy, 0);
    check_val("t12_done", done, 0);
    check_val("t12_rem", steps_remaining, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_move(1, 2, 2, 10, 4, 3);
    wait_done("t12b", 100);
    exp_q = '{10, 10};
    check_gaps("t12b_gap");
    exp_pat = '{4'b1010, 4'b0010};
    check_pats("t12b_pat");

    repeat (2) @(posedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stepper_motion_ctrl.md
# stepper_motion_ctrl

Parametrised successor to the single-speed phase pulse generator. It executes one bounded move per `start`: a fixed number of steps with a trapezoidal (accelerate / cruise / decelerate) step-interval profile, in one of three drive modes. It reports `busy`/`done` and keeps the phase position across moves. It sits between the speed/command logic and the motor driver coil outputs.

## Interface
Parameters:
- `DELAY_W`, 32: width of all delay/interval quantities (clock cycles)
- `STEPS_W`, 16: width of step count and remaining-step counters

Ports:
- `clk`  in  1  system clock; one clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle move request; honoured only in IDLE
- `abort`  in  1  immediate stop request; level-sampled each cycle
- `direction`  in  1  1 = forward (phase index increments), 0 = reverse
- `mode`  in  2  0 = wave full-step, 1 = two-phase full-step, 2/3 = half-step
- `step_count`  in  STEPS_W  steps in the move
- `start_delay`  in  DELAY_W  interval of first/last step (slowest)
- `cruise_delay`  in  DELAY_W  minimum interval (fastest)
- `ramp_dec`  in  DELAY_W  interval change per step while ramping
- `hold_en`  in  1  keep coils energised while idle
- `phases_out`  out  4  coil drive pattern; registered
- `step_pulse`  out  1  one-cycle pulse per issued step
- `busy`  out  1  move in progress
- `done`  out  1  one-cycle pulse on normal completion
- `steps_remaining`  out  STEPS_W  steps still to issue

## Operation
- Phase table, indices 0..7: 1000, 1010, 0010, 0110, 0100, 0101, 0001, 1001.
  - Half-step moves the index ±1 per step.
  - Wave uses the even indices; two-phase uses the odd indices. Both move ±2 per step, mod 8.
  - On the first step of a full-step move with the wrong index parity, the index moves ±1 to reach the correct parity.
- The phase index resets to 0 and is never cleared by `start`.
- `phases_out` is `table[idx]` when `busy` or `hold_en`, else 0000.
- `start` in IDLE latches `direction`, `mode`, `step_count` and all three delays. Inputs are ignored while busy.
- Clamping: delays < 2 are forced to 2. If `start_delay` < `cruise_delay`, `start_delay` is forced to `cruise_delay`, which gives no ramp.
- States:
  - IDLE
  - ACCEL: after each step, `cur_delay` = max(`cur_delay` − `ramp_dec`, `cruise_delay`) and `ramp_steps`++.
  - CRUISE: `cur_delay` is held.
  - DECEL: `cur_delay` = min(`cur_delay` + `ramp_dec`, `start_delay`).
- After each step event:
  - Decrement `steps_remaining`.
  - If it reaches 0, go to IDLE and pulse `done`.
  - Else, from ACCEL/CRUISE, if `steps_remaining` ≤ `ramp_steps`, go to DECEL. The next interval is min(used + `ramp_dec`, `start_delay`).
  - Else, in ACCEL, go to CRUISE once `cur_delay` = `cruise_delay`.
- Arithmetic:
  - Subtraction saturates at `cruise_delay` (no underflow).
  - Addition is computed in DELAY_W+1 bits, then saturated at `start_delay`.
- `step_count` = 0: no step, `busy` stays 0, `done` pulses the cycle after `start`.
- `abort` while busy: go to IDLE next cycle. No further `step_pulse`, no `done`. `steps_remaining` holds; the index keeps its last value.
- `abort` and `start` in the same cycle in IDLE: `abort` wins.
- `abort` coincident with a step event: the step is suppressed.
- `reset_n` low mid-move: outputs return to their reset values immediately.

## Timing
- Reset values:
  - `phases_out` = 0000
  - `step_pulse` = 0, `busy` = 0, `done` = 0
  - `steps_remaining` = 0
  - Phase index = 0, state = IDLE
- `start` sampled at edge N: `busy` = 1 and `steps_remaining` = `step_count` from N+1. The interval counter is cleared at N.
- A step event occurs when counter = `cur_delay` − 1. `step_pulse` and the new `phases_out` appear the following cycle.
- The first `step_pulse` occurs `start_delay` cycles after `busy` rises. Each subsequent gap equals that step's delay.
- `busy` falls and `done` pulses in the same cycle as the final `step_pulse`.

## Structure
- Package `stepper_pkg` holds:
  - the mode enum
  - the FSM state enum
  - the 8-entry phase table constant
  - the minimum-delay constant (2)
- Sub-module `phase_sequencer` holds the phase index, parity correction, ±1/±2 advance and table lookup. Its inputs are advance, direction and mode; its output is the pattern.

## Test plan
- `start_delay`=10, `cruise_delay`=4, `ramp_dec`=3, `step_count`=6, half-step, forward, from reset → six `step_pulse` gaps of 10, 7, 4, 4, 7, 10. `phases_out` runs 1010, 0010, 0110, 0100, 0101, 0001. `done` pulses on the 6th step.
- Same delays, `step_count`=3 → gaps 10, 7, 10. CRUISE is never entered.
- Wave mode from index 1, reverse, `step_count`=2 → patterns 1000, 0001. `phases_out` = 0000 after `done` with `hold_en`=0, and stays 0001 with `hold_en`=1.
- `step_count`=0 → `busy` never rises, `done` pulses 1 cycle after `start`. A `start` while busy is ignored; the counters are unchanged.
- `abort` on the 3rd step-event cycle of a 10-step move → no 3rd `step_pulse`, `busy` falls next cycle, no `done`, `steps_remaining`=8.
- `reset_n` asserted mid-CRUISE → all outputs at reset values within the same cycle. A subsequent `start` begins at `start_delay`.
